// File: rtl/seg7_scan4.sv
// seg7_scan4: four-digit multiplexed 7-segment display driver.
//
// Captures a 16-bit value (four hex nibbles) into a shadow register once
// per frame. It scans the four digits onto one shared segment bus and
// leaves an all-off gap between digits so the display does not ghost.
//
// Parameters:
//   DIV       clock cycles each digit is lit (>= 1)
//   BLANK_CYC clock cycles of all-off gap after each digit (0 = no gap)
//
// Ports:
//   Clk    in   1  system clock, rising edge
//   Reset  in   1  synchronous active-high reset
//   Din    in  16  display value, Din[3:0] = digit 0 (rightmost)
//   Hold   in   1  1 = skip the frame capture at the next wrap
//   Seg    out  7  segments active-high, Seg[6]=A ... Seg[0]=G
//   An     out  4  digit enables active-high, one-hot or all zero
//   Frame  out  1  one-cycle pulse on the cycle after the shadow reloads
//
// Optional build macro:
//   SEG7_LEADING_ZERO_BLANK_EN  blank leading zero digits 3..1
//   (digit 0 is always shown)
module seg7_scan4 #(
  parameter int DIV       = 4,
  parameter int BLANK_CYC = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] Din,
  input  logic        Hold,
  output logic [6:0]  Seg,
  output logic [3:0]  An,
  output logic        Frame
);

  localparam int MAXC = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = (BLANK_CYC > 0) ? CW'(BLANK_CYC - 1) : '0;

  typedef enum logic {S_SHOW = 1'b0, S_BLANK = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   shadow_q, shadow_d;
  logic          frame_q, frame_d;
  logic          adv;

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= S_SHOW;
      idx_q    <= 2'd0;
      cnt_q    <= '0;
      shadow_q <= 16'h0000;
      frame_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      frame_q  <= frame_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CW'(1);
    idx_d    = idx_q;
    shadow_d = shadow_q;
    frame_d  = 1'b0;
    adv      = 1'b0;
    case (state_q)
      S_SHOW: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (BLANK_CYC > 0) state_d = S_BLANK;
          else               adv     = 1'b1;
        end
      end
      default: begin
        if (cnt_q == BLANK_LAST) begin
          cnt_d   = '0;
          adv     = 1'b1;
          state_d = S_SHOW;
        end
      end
    endcase
    if (adv) begin
      idx_d = idx_q + 2'd1;
      // Frame boundary: reload only when not held, so the whole frame
      // shows one consistent value.
      if (idx_q == 2'd3 && !Hold) begin
        shadow_d = Din;
        frame_d  = 1'b1;
      end
    end
  end

  // Output logic (Moore: state, idx and shadow only)
  logic [3:0] nib;
  logic [6:0] seg_dec;
  logic       blank_digit;
  logic [3:1] lead_zero;

  always_comb begin
    nib = shadow_q[{idx_q, 2'b00} +: 4];
    case (nib)
      4'h0: seg_dec = 7'b1111110;
      4'h1: seg_dec = 7'b0110000;
      4'h2: seg_dec = 7'b1101101;
      4'h3: seg_dec = 7'b1111001;
      4'h4: seg_dec = 7'b0110011;
      4'h5: seg_dec = 7'b1011011;
      4'h6: seg_dec = 7'b1011111;
      4'h7: seg_dec = 7'b1110000;
      4'h8: seg_dec = 7'b1111111;
      4'h9: seg_dec = 7'b1111011;
      4'hA: seg_dec = 7'b1110111;
      4'hB: seg_dec = 7'b0011111;
      4'hC: seg_dec = 7'b1001110;
      4'hD: seg_dec = 7'b0111101;
      4'hE: seg_dec = 7'b1001111;
      default: seg_dec = 7'b1000111;
    endcase

    // lead_zero[k]: every nibble from k up to 3 is zero.
    lead_zero[3] = (shadow_q[15:12] == 4'h0);
    lead_zero[2] = lead_zero[3] && (shadow_q[11:8] == 4'h0);
    lead_zero[1] = lead_zero[2] && (shadow_q[7:4] == 4'h0);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    blank_digit = (idx_q != 2'd0) && lead_zero[idx_q];
`else
    blank_digit = 1'b0;
`endif

    if (state_q == S_SHOW) begin
      An  = 4'b0001 << idx_q;
      Seg = blank_digit ? 7'b0000000 : seg_dec;
    end else begin
      An  = 4'b0000;
      Seg = 7'b0000000;
    end
  end

  assign Frame = frame_q;

endmodule

// File: tb/tb_seg7_scan4.sv
module tb_seg7_scan4;

  logic        clk;
  logic        rst, rst2;
  logic [15:0] din, din2;
  logic        hold;
  logic [6:0]  seg, seg2;
  logic [3:0]  an, an2;
  logic        frame, frame2;

  int n_chk = 0;
  int n_err = 0;
  int n     = 0;   // edges since reset release of the default-parameter DUT

  localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101;
  localparam logic [6:0] S5 = 7'b1011011, S8 = 7'b1111111, SA = 7'b1110111;
  localparam logic [6:0] SF = 7'b1000111, SOFF = 7'b0000000;

  seg7_scan4 #(.DIV(4), .BLANK_CYC(1)) dut (
    .Clk(clk), .Reset(rst), .Din(din), .Hold(hold),
    .Seg(seg), .An(an), .Frame(frame)
  );

  seg7_scan4 #(.DIV(1), .BLANK_CYC(0)) dut_fast (
    .Clk(clk), .Reset(rst2), .Din(din2), .Hold(1'b0),
    .Seg(seg2), .An(an2), .Frame(frame2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    assert (got === exp) begin
      $display("check %-14s n=%0d got=%h exp=%h ok", tag, n, got, exp);
    end else begin
      n_err++;
      $error("FAIL %s n=%0d got=%h exp=%h", tag, n, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic adv_to(input int target);
    while (n < target) step();
  endtask

  logic [6:0] exp_lz;

  initial begin
    rst = 1'b1; rst2 = 1'b1; din = 16'h0000; din2 = 16'h0050; hold = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; n = 0;

    // Reset state and first digit/blank timing
    chk("rst_an",    16'(an), 16'(4'b0001));
    chk("rst_seg",   16'(seg), 16'(S0));
    chk("rst_frame", 16'(frame), 16'(1'b0));
    adv_to(4);  chk("blank0_an", 16'(an), 16'(4'b0000));
    chk("blank0_seg", 16'(seg), 16'(SOFF));
    adv_to(5);  chk("dig1_an", 16'(an), 16'(4'b0010));
    adv_to(19); chk("pre_frame", 16'(frame), 16'(1'b0));
    adv_to(20); chk("frame1", 16'(frame), 16'(1'b1));
    chk("frame1_an", 16'(an), 16'(4'b0001));
    adv_to(21); chk("frame1_end", 16'(frame), 16'(1'b0));

    // 0x8A51 captured at n=40, scanned digit by digit
    din = 16'h8A51;
    adv_to(40); chk("f2_frame", 16'(frame), 16'(1'b1));
    chk("f2_d0_an",  16'(an), 16'(4'b0001)); chk("f2_d0_seg", 16'(seg), 16'(S1));
    adv_to(44); chk("f2_b0_an",  16'(an), 16'(4'b0000));
    adv_to(45); chk("f2_d1_an",  16'(an), 16'(4'b0010)); chk("f2_d1_seg", 16'(seg), 16'(S5));
    adv_to(49); chk("f2_b1_an",  16'(an), 16'(4'b0000));
    adv_to(50); chk("f2_d2_an",  16'(an), 16'(4'b0100)); chk("f2_d2_seg", 16'(seg), 16'(SA));
    adv_to(54); chk("f2_b2_an",  16'(an), 16'(4'b0000));
    adv_to(55); chk("f2_d3_an",  16'(an), 16'(4'b1000)); chk("f2_d3_seg", 16'(seg), 16'(S8));
    adv_to(59); chk("f2_b3_an",  16'(an), 16'(4'b0000)); chk("f2_b3_seg", 16'(seg), 16'(SOFF));

    // No tearing: Din changes during digit 2 of the 0x1111 frame
    din = 16'h1111;
    adv_to(71); din = 16'hFFFF;
    adv_to(73); chk("tear_d2", 16'(seg), 16'(S1));
    adv_to(75); chk("tear_d3", 16'(seg), 16'(S1));
    adv_to(80); chk("tear_frame", 16'(frame), 16'(1'b1)); chk("tear_next", 16'(seg), 16'(SF));
    adv_to(95); chk("tear_next_d3", 16'(seg), 16'(SF));

    // Hold across a wrap
    din = 16'h1111;
    adv_to(100); chk("h_load", 16'(seg), 16'(S1));
    adv_to(101); din = 16'h2222; hold = 1'b1;
    adv_to(120); chk("hold_frame", 16'(frame), 16'(1'b0)); chk("hold_seg", 16'(seg), 16'(S1));
    hold = 1'b0;
    adv_to(135); chk("hold_d3", 16'(seg), 16'(S1));
    adv_to(140); chk("rel_frame", 16'(frame), 16'(1'b1)); chk("rel_seg", 16'(seg), 16'(S2));

    // Reset during the blank after digit 2
    adv_to(154); chk("mid_blank", 16'(an), 16'(4'b0000));
    rst = 1'b1;
    step(); rst = 1'b0;
    chk("mid_rst_an",  16'(an), 16'(4'b0001));
    chk("mid_rst_seg", 16'(seg), 16'(S0));
    chk("mid_rst_frm", 16'(frame), 16'(1'b0));
    adv_to(174); chk("mid_pre_frm", 16'(frame), 16'(1'b0));
    adv_to(175); chk("mid_frame", 16'(frame), 16'(1'b1)); chk("mid_seg", 16'(seg), 16'(S2));

    // Reset on the same edge as a wrap
    adv_to(194); rst = 1'b1;
    step(); rst = 1'b0;
    chk("rw_frame", 16'(frame), 16'(1'b0));
    chk("rw_seg",   16'(seg), 16'(S0));

    // DIV=1, BLANK_CYC=0 instance
    step(); rst2 = 1'b0;
    chk("fast_an0", 16'(an2), 16'(4'b0001));
    step(); chk("fast_an1", 16'(an2), 16'(4'b0010));
    step(); chk("fast_an2", 16'(an2), 16'(4'b0100));
    step(); chk("fast_an3", 16'(an2), 16'(4'b1000)); chk("fast_nofrm", 16'(frame2), 16'(1'b0));
    step(); chk("fast_frame", 16'(frame2), 16'(1'b1)); chk("fast_d0", 16'(seg2), 16'(S0));
    step(); chk("fast_d1", 16'(seg2), 16'(S5)); chk("fast_frm_end", 16'(frame2), 16'(1'b0));
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    exp_lz = SOFF;
`else
    exp_lz = S0;
`endif
    step(); chk("fast_d2", 16'(seg2), 16'(exp_lz)); chk("fast_d2_an", 16'(an2), 16'(4'b0100));
    step(); chk("fast_d3", 16'(seg2), 16'(exp_lz)); chk("fast_d3_an", 16'(an2), 16'(4'b1000));
    step(); chk("fast_frame2", 16'(frame2), 16'(1'b1));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
